// File: rtl/booth_vec_sequencer.sv
// booth_vec_sequencer
// Sequencing controller for a vector multiply. Captures LANES signed operand
// pairs and runs them one lane at a time through a single shared iterative
// radix-2 Booth datapath (one Booth step per clock). Returns the packed vector
// of upper W-bit product halves, i.e. bits [2W-1:W] of each exact signed product.
//
// Per-lane schedule: LOAD (1 cycle), STEP (W cycles), STORE (1 cycle).
// out_valid rises LANES*(W+2) edges after the accept edge.

module booth_vec_sequencer #(
    parameter int LANES = 4,
    parameter int W     = 8,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   vec_a,
    input  logic [LANES*W-1:0]   vec_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*W-1:0]   vec_out,
    output logic                 busy,
    output logic [LW-1:0]        lane_idx
);

    // The step counter must be able to hold W-1.
    localparam int CW = $clog2(W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_STORE,
        S_DONE
    } state_t;

    state_t               state;

    // Captured operands, held for the whole transaction so the issue stage
    // may change vec_a/vec_b freely after the accept edge.
    logic [LANES*W-1:0]   a_reg;
    logic [LANES*W-1:0]   b_reg;

    // Booth datapath: A is one bit wider than the operands so the product is
    // exact even for (-2^(W-1)) * (-2^(W-1)).
    logic [W:0]           acc;
    logic [W-1:0]         q;
    logic                 q_1;
    logic [W:0]           m;
    logic [CW-1:0]        cnt;

    logic [W-1:0]         a_lane;
    logic [W-1:0]         b_lane;
    logic [W:0]           booth_sum;

    assign a_lane = a_reg[lane_idx*W +: W];
    assign b_lane = b_reg[lane_idx*W +: W];

    // Booth add/subtract decision on {Q[0], q_1}, applied before the shift.
    always_comb begin
        // NOTE: default assignment first so every path drives booth_sum and no latch is inferred.
        booth_sum = acc;
        unique case ({q[0], q_1})
            2'b01:   booth_sum = acc + m;
            2'b10:   booth_sum = acc - m;
            default: booth_sum = acc;
        endcase
    end

    // Controller FSM, Booth datapath and registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: operand and result registers are cleared too, so nothing from an aborted transaction survives reset.
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            lane_idx  <= '0;
            vec_out   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            q         <= '0;
            q_1       <= 1'b0;
            m         <= '0;
            cnt       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= vec_a;
                        b_reg    <= vec_b;
                        lane_idx <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    acc   <= '0;
                    q     <= b_lane;
                    q_1   <= 1'b0;
                    m     <= {a_lane[W-1], a_lane};
                    cnt   <= '0;
                    state <= S_STEP;
                end

                S_STEP: begin
                    // Arithmetic right shift of {A, Q, q_1} with A's msb replicated.
                    acc <= {booth_sum[W], booth_sum[W:1]};
                    q   <= {booth_sum[0], q[W-1:1]};
                    q_1 <= q[0];
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= S_STORE;
                    end
                end

                S_STORE: begin
                    // A[W-1:0] after the last shift is product bits [2W-1:W].
                    vec_out[lane_idx*W +: W] <= acc[W-1:0];
                    if (lane_idx == LW'(LANES - 1)) begin
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        lane_idx <= lane_idx + LW'(1);
                        state    <= S_LOAD;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        lane_idx  <= '0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_vec_sequencer.sv
// tb_booth_vec_sequencer
// Self-checking bench: table of directed vectors, hand-written reset,
// backpressure and back-to-back sequences, then random vectors against an
// arithmetic reference model ((a*b) >>> W per lane).

module tb_booth_vec_sequencer;

    localparam int LANES = 4;
    localparam int W     = 8;
    localparam int LW    = 2;
    localparam int LAT   = LANES * (W + 2);
    localparam int N_RND = 1000;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   vec_a;
    logic [LANES*W-1:0]   vec_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   vec_out;
    logic                 busy;
    logic [LW-1:0]        lane_idx;

    booth_vec_sequencer #(.LANES(LANES), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vec_a     (vec_a),
        .vec_b     (vec_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_out   (vec_out),
        .busy      (busy),
        .lane_idx  (lane_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int accepts  = 0;
    int aborted  = 0;
    int rises    = 0;
    int acc_cyc  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no response within bound (cycle %0d)", name, cyc);
    endtask

    // Reference: upper W bits of the exact signed product, lane by lane.
    function automatic logic [LANES*W-1:0] model(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b);
        logic [LANES*W-1:0] r;
        longint p;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            p = longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
            p = p >>> W;
            r[i*W +: W] = p[W-1:0];
        end
        return r;
    endfunction

    // Every rising out_valid must be backed by a transaction that was accepted and not aborted.
    logic ov_q = 1'b0;
    always @(negedge clk) begin
        if (rst_n && out_valid && !ov_q) begin
            check("out_valid_has_accept", rises < (accepts - aborted), 1'b1);
            rises++;
        end
        ov_q = out_valid;
    end

    task automatic start_txn(input logic [LANES*W-1:0] a, input logic [LANES*W-1:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) fail("accept_wait");
        vec_a    = a;
        vec_b    = b;
        in_valid = 1'b1;
        @(negedge clk);
        acc_cyc  = cyc;
        accepts++;
        in_valid = 1'b0;
        vec_a    = $urandom;
        vec_b    = $urandom;
    endtask

    task automatic wait_result(output logic [LANES*W-1:0] res);
        int k;
        k = 0;
        while (!out_valid && k < 100) begin
            check("busy_running", busy, 1'b1);
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            fail("result_wait");
            res = 'x;
        end else begin
            check("latency", cyc - acc_cyc, LAT);
            check("busy_done", busy, 1'b0);
            check("in_ready_done", in_ready, 1'b0);
            res = vec_out;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1'b1);
        check("out_valid_after_hs", out_valid, 1'b0);
    endtask

    typedef struct {
        string              name;
        logic [LANES*W-1:0] a;
        logic [LANES*W-1:0] b;
        logic [LANES*W-1:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [LANES*W-1:0] r;
        logic [LANES*W-1:0] ra, rb;
        logic [LANES*W-1:0] va[2];
        logic [LANES*W-1:0] vb[2];
        logic [LANES*W-1:0] res[2];
        int acc_e[2];
        int n_acc, n_hs;
        bit swap;

        // Lane 0 in the low byte.
        tbl[0] = '{"directed", 32'h80FF7F10, 32'h80010210, 32'h40FF0001};
        tbl[1] = '{"boundary", 32'h7F008080, 32'h7F807F01, 32'h3F00C0FF};
        tbl[2] = '{"min_x_min", 32'h80808080, 32'h80808080, 32'h40404040};
        tbl[3] = '{"max_x_min", 32'h7F7F7F7F, 32'h80808080, 32'hC0C0C0C0};
        tbl[4] = '{"small", 32'h03030303, 32'h05050505, 32'h00000000};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vec_a = '0; vec_b = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_vec_out", vec_out, '0);
        check("rst_lane_idx", lane_idx, '0);

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            start_txn(tbl[i].a, tbl[i].b);
            wait_result(r);
            check(tbl[i].name, r, tbl[i].exp);
            handshake();
            check({tbl[i].name, "_lane_idx_idle"}, lane_idx, '0);
        end

        // Reset in the middle of lane 1's STEP phase; lane 0 already holds a non-zero result.
        start_txn(tbl[0].a, tbl[0].b);
        repeat (11) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_lane_idx", lane_idx, 2'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        aborted++;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_vec_out", vec_out, '0);
        check("midrst_lane_idx", lane_idx, '0);
        repeat (LAT + 5) begin
            @(negedge clk);
            check("midrst_no_partial", out_valid, 1'b0);
        end
        start_txn(tbl[4].a, tbl[4].b);
        wait_result(r);
        check("after_rst_small", r, tbl[4].exp);
        handshake();

        // Backpressure: hold the result for 5 cycles while in_valid pulses.
        start_txn(tbl[1].a, tbl[1].b);
        wait_result(r);
        check("bp_result", r, tbl[1].exp);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            vec_a    = $urandom;
            vec_b    = $urandom;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_vec_out", vec_out, tbl[1].exp);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        handshake();

        // Back-to-back with in_valid and out_ready held high.
        va[0] = tbl[0].a; vb[0] = tbl[0].b;
        va[1] = tbl[1].a; vb[1] = tbl[1].b;
        n_acc = 0; n_hs = 0; swap = 1'b0;
        @(negedge clk);
        vec_a = va[0]; vec_b = vb[0]; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 200 && n_hs < 2; k++) begin
            if (swap) begin
                swap = 1'b0;
                if (n_acc == 1) begin
                    vec_a = va[1];
                    vec_b = vb[1];
                end else begin
                    in_valid = 1'b0;
                end
            end
            check("b2b_busy", busy, !(in_ready || out_valid));
            if (in_valid && in_ready && n_acc < 2) begin
                acc_e[n_acc] = cyc + 1;
                n_acc++;
                accepts++;
                swap = 1'b1;
            end
            if (out_valid && out_ready) begin
                res[n_hs] = vec_out;
                n_hs++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (n_hs < 2 || n_acc < 2) begin
            fail("b2b_results");
        end else begin
            check("b2b_spacing", acc_e[1] - acc_e[0], LAT + 2);
            check("b2b_res0", res[0], tbl[0].exp);
            check("b2b_res1", res[1], tbl[1].exp);
        end

        // Random vectors against the arithmetic model.
        for (int i = 0; i < N_RND; i++) begin
            ra = $urandom;
            rb = $urandom;
            start_txn(ra, rb);
            wait_result(r);
            check("random", r, model(ra, rb));
            handshake();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
